// File: rtl/dand_uart_pkg.sv
// Shared types and constants for the UART receive path.
package dand_uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/dand_uart_rx_if.sv
// Valid/ready byte stream carrying received UART data to its consumer.
interface dand_uart_rx_if;
    import dand_uart_pkg::*;

    logic                      io_rx_valid;
    logic                      io_rx_ready;
    logic [UART_DATA_BITS-1:0] io_rx_payload;

    modport master (output io_rx_valid, output io_rx_payload, input io_rx_ready);
    modport slave  (input io_rx_valid, input io_rx_payload, output io_rx_ready);

endinterface

// File: rtl/dand_uart_rx_fifo.sv
// Synchronous FIFO for received bytes; head is read directly from storage (no fall-through).
module dand_uart_rx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_pop;
    logic             do_push;

    assign occupancy = wr_ptr_q - rd_ptr_q;
    assign full      = (occupancy == (AW + 1)'(DEPTH));
    assign empty     = (occupancy == '0);
    assign head      = mem_q[rd_ptr_q[AW-1:0]];

    // When full, a same-cycle pop frees the head slot that the write pointer aliases.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d                = wr_ptr_q + (AW + 1)'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            mem_q    <= '{default: '0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/dand_uart_rx.sv
// Oversampling UART receiver: sync, tick divider, majority vote, deframing FSM, byte FIFO.
module dand_uart_rx
    import dand_uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = 8,
    parameter int unsigned DIV_WIDTH  = 16,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          io_axiClk,
    input  logic                          io_resetn,
    input  logic                          io_uart_rxd,
    input  logic [DIV_WIDTH-1:0]          io_clkDivider,
    input  logic                          io_parityEn,
    input  logic                          io_parityOdd,
    input  logic                          io_stopBits2,
    dand_uart_rx_if.master                rx,
    output logic [$clog2(FIFO_DEPTH):0]   io_rxOccupancy,
    output logic                          io_frameError,
    output logic                          io_parityError,
    output logic                          io_overflow,
    input  logic                          io_clearErrors
);

    localparam int unsigned SW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(UART_DATA_BITS);
    localparam logic [SW-1:0] SAMP_A = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SAMP_B = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] SAMP_C = SW'(OVERSAMPLE / 2 + 1);

    rx_state_e                 state_q, state_d;
    logic [1:0]                sync_q, sync_d;
    logic                      rxd_prev_q, rxd_prev_d;
    logic [DIV_WIDTH-1:0]      tick_cnt_q, tick_cnt_d;
    logic [SW-1:0]             samp_q, samp_d;
    logic                      s0_q, s0_d;
    logic                      s1_q, s1_d;
    logic [BW-1:0]             bit_cnt_q, bit_cnt_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      stop2_q, stop2_d;
    logic                      par_bad_q, par_bad_d;
    logic                      frame_err_q, frame_err_d;
    logic                      par_err_q, par_err_d;
    logic                      ovf_q, ovf_d;

    logic rxd;
    logic tick;
    logic decide;
    logic maj;
    logic push;
    logic frame_set;
    logic par_set;
    logic fifo_full;
    logic fifo_empty;

    assign rxd = sync_q[1];

    always_comb begin
        sync_d      = {sync_q[0], io_uart_rxd};
        rxd_prev_d  = rxd;
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        samp_d      = samp_q;
        s0_d        = s0_q;
        s1_d        = s1_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        stop2_d     = stop2_q;
        par_bad_d   = par_bad_q;
        push        = 1'b0;
        frame_set   = 1'b0;
        par_set     = 1'b0;

        tick   = (state_q != IDLE) && (tick_cnt_q == '0);
        decide = tick && (samp_q == SAMP_C);
        maj    = majority3(s0_q, s1_q, rxd);

        if (state_q == IDLE || tick) begin
            tick_cnt_d = io_clkDivider;
        end else begin
            tick_cnt_d = tick_cnt_q - DIV_WIDTH'(1);
        end

        if (tick) begin
            samp_d = samp_q + SW'(1);
            if (samp_q == SAMP_A) s0_d = rxd;
            if (samp_q == SAMP_B) s1_d = rxd;
        end

        // Bit decisions land mid-bit; the sample counter free-runs so later bits stay aligned.
        unique case (state_q)
            IDLE: begin
                samp_d = '0;
                if (rxd_prev_q && !rxd) state_d = START;
            end
            START: begin
                if (decide) begin
                    if (maj) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
            end
            DATA: begin
                if (decide) begin
                    shift_d   = {maj, shift_q[UART_DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + BW'(1);
                    if (bit_cnt_q == BW'(UART_DATA_BITS - 1)) begin
                        state_d   = io_parityEn ? PARITY : STOP;
                        stop2_d   = 1'b0;
                        par_bad_d = 1'b0;
                    end
                end
            end
            PARITY: begin
                if (decide) begin
                    par_bad_d = (maj != ((^shift_q) ^ io_parityOdd));
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (decide) begin
                    if (!maj) begin
                        frame_set = 1'b1;
                        state_d   = BREAK;
                    end else if (io_stopBits2 && !stop2_q) begin
                        stop2_d = 1'b1;
                    end else begin
                        push    = 1'b1;
                        par_set = par_bad_q;
                        state_d = IDLE;
                    end
                end
            end
            BREAK: begin
                if (rxd) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        frame_err_d = (frame_err_q & ~io_clearErrors) | frame_set;
        par_err_d   = (par_err_q & ~io_clearErrors) | par_set;
        ovf_d       = (ovf_q & ~io_clearErrors)
                    | (push & fifo_full & ~(rx.io_rx_ready & ~fifo_empty));
    end

    always_ff @(posedge io_axiClk) begin
        if (!io_resetn) begin
            state_q     <= IDLE;
            sync_q      <= '1;
            rxd_prev_q  <= 1'b1;
            tick_cnt_q  <= '0;
            samp_q      <= '0;
            s0_q        <= 1'b1;
            s1_q        <= 1'b1;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            stop2_q     <= 1'b0;
            par_bad_q   <= 1'b0;
            frame_err_q <= 1'b0;
            par_err_q   <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            rxd_prev_q  <= rxd_prev_d;
            tick_cnt_q  <= tick_cnt_d;
            samp_q      <= samp_d;
            s0_q        <= s0_d;
            s1_q        <= s1_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            stop2_q     <= stop2_d;
            par_bad_q   <= par_bad_d;
            frame_err_q <= frame_err_d;
            par_err_q   <= par_err_d;
            ovf_q       <= ovf_d;
        end
    end

    dand_uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk       (io_axiClk),
        .resetn    (io_resetn),
        .push      (push),
        .push_data (shift_q),
        .pop       (rx.io_rx_ready),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (rx.io_rx_payload),
        .occupancy (io_rxOccupancy)
    );

    assign rx.io_rx_valid = ~fifo_empty;
    assign io_frameError  = frame_err_q;
    assign io_parityError = par_err_q;
    assign io_overflow    = ovf_q;

endmodule

// File: tb/tb_dand_uart_rx.sv
// Directed bench for dand_uart_rx at div=0, 8x oversampling (8 clocks per bit).
module tb_dand_uart_rx;
    import dand_uart_pkg::*;

    localparam int unsigned BIT = 8;

    logic        clk = 1'b0;
    logic        resetn;
    logic        rxd;
    logic [15:0] div;
    logic        par_en;
    logic        par_odd;
    logic        stop2;
    logic        clear;
    logic [4:0]  occ;
    logic        frame_err;
    logic        par_err;
    logic        ovf;

    int n_cmp = 0;
    int n_err = 0;

    dand_uart_rx_if u_if ();

    dand_uart_rx #(
        .OVERSAMPLE (8),
        .DIV_WIDTH  (16),
        .FIFO_DEPTH (16)
    ) dut (
        .io_axiClk      (clk),
        .io_resetn      (resetn),
        .io_uart_rxd    (rxd),
        .io_clkDivider  (div),
        .io_parityEn    (par_en),
        .io_parityOdd   (par_odd),
        .io_stopBits2   (stop2),
        .rx             (u_if.master),
        .io_rxOccupancy (occ),
        .io_frameError  (frame_err),
        .io_parityError (par_err),
        .io_overflow    (ovf),
        .io_clearErrors (clear)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic line_bit(input logic v);
        rxd = v;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic with_par, input logic par_bit,
                              input logic stop_a, input logic stop_b, input int nstop);
        line_bit(1'b0);
        for (int i = 0; i < 8; i++) line_bit(data[i]);
        if (with_par) line_bit(par_bit);
        line_bit(stop_a);
        if (nstop > 1) line_bit(stop_b);
        rxd = 1'b1;
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] exp);
        check({tag, "_valid"}, 32'(u_if.io_rx_valid), 32'h1);
        check({tag, "_data"}, 32'(u_if.io_rx_payload), 32'(exp));
        u_if.io_rx_ready = 1'b1;
        @(negedge clk);
        u_if.io_rx_ready = 1'b0;
    endtask

    task automatic clear_errors();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int lat;
        resetn = 1'b0;
        rxd = 1'b1;
        div = '0;
        par_en = 1'b0;
        par_odd = 1'b0;
        stop2 = 1'b0;
        clear = 1'b0;
        u_if.io_rx_ready = 1'b0;
        repeat (4) @(negedge clk);

        check("rst_valid", 32'(u_if.io_rx_valid), 32'h0);
        check("rst_payload", 32'(u_if.io_rx_payload), 32'h0);
        check("rst_occ", 32'(occ), 32'h0);
        check("rst_flags", {29'h0, frame_err, par_err, ovf}, 32'h0);
        check("rst_state", 32'(dut.state_q), 32'(IDLE));
        resetn = 1'b1;
        idle(10);

        // 8N1 0xA5 with latency from the start edge to valid
        fork
            send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 1);
            begin
                lat = 0;
                while (!u_if.io_rx_valid && lat < 200) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        check("a5_latency_window", 32'(lat >= 72 && lat <= 90), 32'h1);
        idle(8);
        check("a5_occ", 32'(occ), 32'h1);
        check("a5_flags", {29'h0, frame_err, par_err, ovf}, 32'h0);
        pop_expect("a5", 8'hA5);
        check("a5_drained", 32'(u_if.io_rx_valid), 32'h0);

        // 3-clock glitch must be rejected by the start-bit vote
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        idle(40);
        check("glitch_valid", 32'(u_if.io_rx_valid), 32'h0);
        check("glitch_state", 32'(dut.state_q), 32'(IDLE));
        check("glitch_flags", {29'h0, frame_err, par_err, ovf}, 32'h0);

        // Even parity, 0x03 carries wrong parity bit 1
        par_en = 1'b1;
        par_odd = 1'b0;
        idle(4);
        send_frame(8'h03, 1'b1, 1'b1, 1'b1, 1'b1, 1);
        idle(10);
        check("par_err_set", 32'(par_err), 32'h1);
        pop_expect("par_even_bad", 8'h03);
        clear_errors();
        check("par_err_clr", 32'(par_err), 32'h0);

        // Odd parity, 0x03 with correct parity bit 1
        par_odd = 1'b1;
        idle(4);
        send_frame(8'h03, 1'b1, 1'b1, 1'b1, 1'b1, 1);
        idle(10);
        check("par_odd_ok", 32'(par_err), 32'h0);
        pop_expect("par_odd", 8'h03);
        par_en = 1'b0;
        par_odd = 1'b0;

        // Stop bit low on 0x55: discarded, frame error, then 0x12 accepted
        idle(4);
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        idle(16);
        check("ferr_set", 32'(frame_err), 32'h1);
        check("ferr_nopush", 32'(occ), 32'h0);
        send_frame(8'h12, 1'b0, 1'b0, 1'b1, 1'b1, 1);
        idle(10);
        pop_expect("after_ferr", 8'h12);
        clear_errors();
        check("ferr_clr", 32'(frame_err), 32'h0);

        // Two stop bits: second stop low is a framing error
        stop2 = 1'b1;
        idle(4);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 2);
        idle(16);
        check("stop2_ferr", 32'(frame_err), 32'h1);
        check("stop2_nopush", 32'(occ), 32'h0);
        clear_errors();
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 1'b1, 2);
        idle(10);
        check("stop2_ok_flag", 32'(frame_err), 32'h0);
        pop_expect("stop2_ok", 8'hC3);
        stop2 = 1'b0;

        // 17 back-to-back bytes into a 16-deep FIFO with no consumer
        idle(4);
        for (int i = 0; i < 17; i++) send_frame(8'h30 + 8'(i), 1'b0, 1'b0, 1'b1, 1'b1, 1);
        idle(16);
        check("ovf_occ", 32'(occ), 32'd16);
        check("ovf_flag", 32'(ovf), 32'h1);
        for (int i = 0; i < 16; i++) pop_expect($sformatf("ovf_pop%0d", i), 8'h30 + 8'(i));
        check("ovf_drained", 32'(u_if.io_rx_valid), 32'h0);
        clear_errors();
        check("ovf_clr", 32'(ovf), 32'h0);

        // Reset in the middle of 0x7E data bits, with one byte already queued
        idle(4);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 1);
        idle(10);
        check("pre_rst_occ", 32'(occ), 32'h1);
        line_bit(1'b0);
        line_bit(1'b0);
        line_bit(1'b1);
        line_bit(1'b1);
        check("pre_rst_state", 32'(dut.state_q), 32'(DATA));
        resetn = 1'b0;
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_occ", 32'(occ), 32'h0);
        check("midrst_valid", 32'(u_if.io_rx_valid), 32'h0);
        check("midrst_state", 32'(dut.state_q), 32'(IDLE));
        resetn = 1'b1;
        idle(10);
        send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b1, 1);
        idle(10);
        check("post_rst_occ", 32'(occ), 32'h1);
        pop_expect("post_rst", 8'h81);
        check("post_rst_flags", {29'h0, frame_err, par_err, ovf}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
